mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Uses a valid/ready request channel and a valid/ready response channel per side.
- Serialises transactions (one outstanding at a time), registers the winning request, and forwards the response back to its owner.
- A watchdog counter converts a hung bus transaction into an error response.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (mask width = DATA_W/8)
- TIMEOUT, 255, max cycles from mem request issue to response handshake; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch response valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  bus/timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  response valid
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  load data
- lsu_resp_err  out  1  error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  registered request fields
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  arbiter takes response
- mem_rdata  in  DATA_W  read data
- mem_resp_err  in  1  slave error
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, RESP, ERR. Internal owner bit: 0=IFU, 1=LSU.
- Reset: state=IDLE, owner=0, counter=0, request registers=0. All valid outputs and busy are 0, all data outputs are 0. In IDLE, ifu_req_ready/lsu_req_ready follow arbitration and are not forced 0.
- IDLE arbitration:
  - Fixed priority, LSU > IFU.
  - lsu_req_ready=1. ifu_req_ready = !lsu_req_valid.
  - On a request handshake: latch addr, wen, wdata and wmask (IFU: wen=0, wdata=0, wmask=0), set owner, clear counter, go to REQ.
  - Both valid in the same cycle: LSU wins; IFU stays pending with ready=0.
- REQ:
  - mem_req_valid=1, driven from registers, stable until mem_req_ready.
  - On handshake go to RESP. Both master ready outputs are 0.
- RESP:
  - Owner's resp_valid = mem_resp_valid; rdata/err pass through combinationally. mem_resp_ready = owner's resp_ready.
  - The non-owner's resp_valid is 0.
  - On the mem_resp_valid & ready handshake go to IDLE.
- Watchdog:
  - Counter increments every cycle in REQ and RESP.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no completing handshake that cycle, go to ERR.
  - A handshake in that same cycle takes precedence: normal completion.
  - Exiting REQ on timeout drops mem_req_valid (the transaction is abandoned).
- ERR:
  - Owner's resp_valid=1, resp_err=1, rdata=0. Hold until owner resp_ready, then go to IDLE.
  - mem_resp_ready=1 in ERR and IDLE: stray late responses are consumed and discarded, never forwarded.
- Latency: master handshake in cycle N → mem_req_valid in N+1. If memory is ready at N+1 and responds at N+2, the response is visible to the owner at N+2 and the next request can be accepted at N+3.
- Response backpressure: the owner holding resp_ready=0 keeps RESP/ERR indefinitely. The watchdog also counts during this stall.
- Reset mid-transaction: immediate return to IDLE next edge. The in-flight transaction is abandoned; no response is delivered.
- Outputs combinational from state/registers only; no combinational path from ifu_req_valid to mem_req_valid.

Test Plan:
- IFU-only fetch at addr 0x8000_0000, memory ready immediately, rdata 0x0000_0413 at next cycle → mem_req_valid cycle N+1, ifu_resp_valid/rdata 0x0000_0413 cycle N+2, err=0, busy low at N+3.
- IFU and LSU valid in the same cycle (LSU store 0x8000_0100, wdata 0xDEADBEEF, wmask 0xF) → LSU served first with mem_wen=1 and the exact data; IFU ready only after return to IDLE; IFU served second.
- mem_req_ready held 0 for 3 cycles, then 1 → mem_addr/wdata stable all 4 cycles; single response to owner.
- TIMEOUT=8, memory never responds to LSU load → ERR entered 8 cycles after REQ entry; lsu_resp_valid=1, err=1, rdata=0; a late mem response after return to IDLE is drained and not forwarded.
- Owner holds resp_ready=0 for 5 cycles in RESP → mem_resp_ready=0 throughout; completion on the first cycle both are high.
- rst asserted while in RESP → next cycle IDLE, busy=0, all valids 0; a fresh IFU request is then handled normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (IFU read-only, LSU read/write), one outstanding
// transaction at a time, with a watchdog that turns a hung transaction into an error.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_resp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  // Counter only has to reach TIMEOUT-1
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t                state, state_nxt;
  logic                  owner;
  logic [CW-1:0]         cnt;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  owner_resp_ready;
  logic                  timeout;

  assign owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;
  assign timeout          = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (lsu_req_valid) begin
          owner     <= 1'b1;
          cnt       <= '0;
          req_addr  <= lsu_addr;
          req_wen   <= lsu_wen;
          req_wdata <= lsu_wdata;
          req_wmask <= lsu_wmask;
        end else if (ifu_req_valid) begin
          owner     <= 1'b0;
          cnt       <= '0;
          req_addr  <= ifu_addr;
          req_wen   <= 1'b0;
          req_wdata <= '0;
          req_wmask <= '0;
        end
      end else if (state == REQ || state == RESP) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A completing handshake in the timeout cycle wins over the watchdog
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_req_valid || ifu_req_valid) state_nxt = REQ;
      REQ: begin
        if (mem_req_ready)  state_nxt = RESP;
        else if (timeout)   state_nxt = ERR;
      end
      RESP: begin
        if (mem_resp_valid && owner_resp_ready) state_nxt = IDLE;
        else if (timeout)                       state_nxt = ERR;
      end
      ERR: if (owner_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    case (state)
      IDLE: begin
        lsu_req_ready  = 1'b1;
        ifu_req_ready  = !lsu_req_valid;
        mem_resp_ready = 1'b1;
      end
      REQ: mem_req_valid = 1'b1;
      RESP: begin
        mem_resp_ready = owner_resp_ready;
        if (owner) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
          lsu_resp_err   = mem_resp_err;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
          ifu_resp_err   = mem_resp_err;
        end
      end
      ERR: begin
        mem_resp_ready = 1'b1;
        if (owner) begin
          lsu_resp_valid = 1'b1;
          lsu_resp_err   = 1'b1;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_resp_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_addr  = req_addr;
  assign mem_wen   = req_wen;
  assign mem_wdata = req_wdata;
  assign mem_wmask = req_wmask;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// transaction loop checked against a transaction-level expectation.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 1;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_resp_ready = 1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; mem_resp_err = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      failures++; $display("FAIL rst_valids got=%b exp=000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
      failures++; $display("FAIL rst_mem_fields got=%h/%h/%h/%b exp=0", mem_addr, mem_wdata, mem_wmask, mem_wen);
    end
    checks++;
    if ({ifu_rdata, lsu_rdata} !== 64'd0) begin
      failures++; $display("FAIL rst_rdata got=%h/%h exp=0", ifu_rdata, lsu_rdata);
    end
    checks++;
    if ({lsu_req_ready, ifu_req_ready, mem_resp_ready} !== 3'b111) begin
      failures++; $display("FAIL rst_readys got=%b exp=111", {lsu_req_ready, ifu_req_ready, mem_resp_ready});
    end
    checks++;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_ifu_fetch();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #1;
    if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL fetch_req_ready got=%b exp=1", ifu_req_ready); end
    checks++;
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 1; #1;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
      failures++; $display("FAIL fetch_mem_req got=v%b a=%h w=%b exp=v1 a=80000000 w=0", mem_req_valid, mem_addr, mem_wen);
    end
    checks++;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413; #1;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_resp_err !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_resp got=v%b d=%h e=%b lv=%b exp=v1 d=00000413 e0 lv0",
                           ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_resp_valid);
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0; #1;
    if (busy !== 1'b0) begin failures++; $display("FAIL fetch_idle busy got=%b exp=0", busy); end
    checks++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
    #1;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      failures++; $display("FAIL prio_ready got=l%b i%b exp=l1 i0", lsu_req_ready, ifu_req_ready);
    end
    checks++;
    @(negedge clk);
    lsu_req_valid = 0; mem_req_ready = 1; #1;
    if (mem_wen !== 1'b1 || mem_addr !== 32'h8000_0100 || mem_wdata !== 32'hDEADBEEF || mem_wmask !== 4'hF) begin
      failures++; $display("FAIL prio_lsu_fields got=w%b a=%h d=%h m=%h exp=w1 a=80000100 d=deadbeef m=f",
                           mem_wen, mem_addr, mem_wdata, mem_wmask);
    end
    checks++;
    if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL prio_ifu_blocked got=%b exp=0", ifu_req_ready); end
    checks++;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1111_2222; #1;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      failures++; $display("FAIL prio_lsu_resp got=lv%b iv%b ir%b exp=lv1 iv0 ir0", lsu_resp_valid, ifu_resp_valid, ifu_req_ready);
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0; #1;
    if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL prio_ifu_ready_idle got=%b exp=1", ifu_req_ready); end
    checks++;
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 1; #1;
    if (mem_addr !== 32'h8000_0040 || mem_wen !== 1'b0 || mem_wdata !== 32'd0 || mem_wmask !== 4'd0) begin
      failures++; $display("FAIL prio_ifu_fields got=a%h w%b d%h m%h exp=a80000040 w0 d0 m0", mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    checks++;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0013; #1;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0013 || lsu_resp_valid !== 1'b0) begin
      failures++; $display("FAIL prio_ifu_resp got=iv%b d%h lv%b exp=iv1 d00000013 lv0", ifu_resp_valid, ifu_rdata, lsu_resp_valid);
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0; lsu_wen = 0;
  endtask

  task automatic test_req_stall();
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lsu_req_valid = 0; mem_req_ready = (k == 3); #1;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0200 || mem_wdata !== 32'hCAFE_F00D || mem_wmask !== 4'h3) begin
        failures++; $display("FAIL stall_hold[%0d] got=v%b a%h d%h m%h exp=v1 a80000200 dcafef00d m3",
                             k, mem_req_valid, mem_addr, mem_wdata, mem_wmask);
      end
      checks++;
    end
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = '0; #1;
    if (lsu_resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL stall_resp got=lv%b mv%b exp=lv1 mv0", lsu_resp_valid, mem_req_valid);
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0; lsu_wen = 0; #1;
    if (lsu_resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stall_single_resp got=lv%b busy%b exp=lv0 busy0", lsu_resp_valid, busy);
    end
    checks++;
  endtask

  task automatic test_timeout();
    // LSU load: request accepted, memory never responds
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0; lsu_resp_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lsu_req_valid = 0; mem_req_ready = (k == 1); #1;
      if (lsu_resp_valid !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL to_wait[%0d] got=lv%b busy%b exp=lv0 busy1", k, lsu_resp_valid, busy);
      end
      checks++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_req_ready = 0; lsu_resp_ready = (k == 1); #1;
      if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b1 || lsu_rdata !== 32'd0 || mem_resp_ready !== 1'b1) begin
        failures++; $display("FAIL to_err[%0d] got=v%b e%b d%h mr%b exp=v1 e1 d0 mr1",
                             k, lsu_resp_valid, lsu_resp_err, lsu_rdata, mem_resp_ready);
      end
      checks++;
    end
    @(negedge clk);
    mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA; #1;
    if (lsu_resp_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL to_late_drain got=lv%b iv%b mr%b busy%b exp=lv0 iv0 mr1 busy0",
                           lsu_resp_valid, ifu_resp_valid, mem_resp_ready, busy);
    end
    checks++;
    // IFU fetch that is never accepted by memory: abandoned from REQ
    @(negedge clk);
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0400;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ifu_req_valid = 0; #1;
      if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL to_req_hold[%0d] got=%b exp=1", k, mem_req_valid); end
      checks++;
    end
    @(negedge clk);
    #1;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b1 || ifu_resp_err !== 1'b1 || ifu_rdata !== 32'd0) begin
      failures++; $display("FAIL to_req_abandon got=mv%b iv%b e%b d%h exp=mv0 iv1 e1 d0",
                           mem_req_valid, ifu_resp_valid, ifu_resp_err, ifu_rdata);
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0500;
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0BAD_CAFE; ifu_resp_ready = (k == 5); #1;
      if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0BAD_CAFE || mem_resp_ready !== (k == 5)) begin
        failures++; $display("FAIL bp_hold[%0d] got=v%b d%h mr%b exp=v1 d0badcafe mr%0d",
                             k, ifu_resp_valid, ifu_rdata, mem_resp_ready, (k == 5));
      end
      checks++;
    end
    @(negedge clk);
    mem_resp_valid = 0; #1;
    if (busy !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_done got=busy%b iv%b exp=busy0 iv0", busy, ifu_resp_valid);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0600; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hC;
    @(negedge clk);
    lsu_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; rst = 1; #1;
    if (busy !== 1'b1) begin failures++; $display("FAIL rmid_in_resp busy got=%b exp=1", busy); end
    checks++;
    @(negedge clk);
    rst = 0; mem_resp_valid = 1; #1;
    if (busy !== 1'b0 || {mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      failures++; $display("FAIL rmid_idle got=busy%b valids%b exp=busy0 valids000",
                           busy, {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0; lsu_wen = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0700;
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 1; #1;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0700 || mem_wen !== 1'b0) begin
      failures++; $display("FAIL rmid_fresh_req got=v%b a%h w%b exp=v1 a80000700 w0", mem_req_valid, mem_addr, mem_wen);
    end
    checks++;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0093; #1;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0093) begin
      failures++; $display("FAIL rmid_fresh_resp got=v%b d%h exp=v1 d00000093", ifu_resp_valid, ifu_rdata);
    end
    checks++;
    @(negedge clk);
    mem_resp_valid = 0;
  endtask

  // Reference: LSU wins whenever it requests; an IFU request is a read with zero
  // data/strobes; the owner alone sees exactly the memory's response.
  task automatic test_random();
    logic        lv, iv, exp_lsu, exp_wen, er;
    logic [31:0] la, ia, wd, exp_addr, exp_wdata, rd;
    logic [3:0]  wm, exp_wmask;
    int unsigned wait_req, lat, stall;
    for (int t = 0; t < 60; t++) begin
      lv = 1'($urandom_range(0, 1)); iv = 1'($urandom_range(0, 1));
      if (!lv && !iv) iv = 1'b1;
      la = $urandom; ia = $urandom; wd = $urandom; wm = 4'($urandom);
      exp_lsu   = lv;
      exp_addr  = lv ? la : ia;
      exp_wen   = lv ? (t % 2 == 0) : 1'b0;
      exp_wdata = lv ? wd : 32'd0;
      exp_wmask = lv ? wm : 4'd0;
      @(negedge clk);
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = (t % 2 == 0); lsu_wdata = wd; lsu_wmask = wm;
      ifu_req_valid = iv; ifu_addr = ia; #1;
      if (lsu_req_ready !== 1'b1 || ifu_req_ready !== !lv) begin
        failures++; $display("FAIL rnd_arb[%0d] got=l%b i%b exp=l1 i%b", t, lsu_req_ready, ifu_req_ready, !lv);
      end
      checks++;
      wait_req = $urandom_range(0, 2);
      for (int unsigned k = 0; k <= wait_req; k++) begin
        @(negedge clk);
        lsu_req_valid = 0; ifu_req_valid = 0; mem_req_ready = (k == wait_req); #1;
        if (mem_req_valid !== 1'b1 || mem_addr !== exp_addr || mem_wen !== exp_wen ||
            mem_wdata !== exp_wdata || mem_wmask !== exp_wmask) begin
          failures++; $display("FAIL rnd_req[%0d] got=v%b a%h w%b d%h m%h exp=v1 a%h w%b d%h m%h", t,
                               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                               exp_addr, exp_wen, exp_wdata, exp_wmask);
        end
        checks++;
      end
      lat = $urandom_range(0, 2);
      for (int unsigned k = 0; k < lat; k++) begin
        @(negedge clk);
        mem_req_ready = 0; #1;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
          failures++; $display("FAIL rnd_wait[%0d] got=iv%b lv%b exp=0 0", t, ifu_resp_valid, lsu_resp_valid);
        end
        checks++;
      end
      rd = $urandom; er = 1'($urandom_range(0, 1)); stall = $urandom_range(0, 1);
      for (int unsigned k = 0; k <= stall; k++) begin
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = rd; mem_resp_err = er;
        if (exp_lsu) begin lsu_resp_ready = (k == stall); ifu_resp_ready = 1'($urandom_range(0, 1)); end
        else         begin ifu_resp_ready = (k == stall); lsu_resp_ready = 1'($urandom_range(0, 1)); end
        #1;
        if (exp_lsu ? (lsu_resp_valid !== 1'b1 || lsu_rdata !== rd || lsu_resp_err !== er || ifu_resp_valid !== 1'b0)
                    : (ifu_resp_valid !== 1'b1 || ifu_rdata !== rd || ifu_resp_err !== er || lsu_resp_valid !== 1'b0)) begin
          failures++; $display("FAIL rnd_resp[%0d] got=iv%b id%h ie%b lv%b ld%h le%b exp owner_lsu=%b d%h e%b", t,
                               ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_resp_valid, lsu_rdata, lsu_resp_err,
                               exp_lsu, rd, er);
        end
        checks++;
        if (mem_resp_ready !== (k == stall)) begin
          failures++; $display("FAIL rnd_mem_ready[%0d] got=%b exp=%0d", t, mem_resp_ready, (k == stall));
        end
        checks++;
      end
      @(negedge clk);
      mem_resp_valid = 0; mem_resp_err = 0; ifu_resp_ready = 1; lsu_resp_ready = 1; #1;
      if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle[%0d] busy got=%b exp=0", t, busy); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_priority();
    test_req_stall();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
